// File: rtl/sc_pkg.sv
// rtl/sc_pkg.sv - shared FSM state type, sizing helpers and LFSR tap table for the stochastic matmul engine
package sc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_IN,
    LOAD_W,
    COMPUTE,
    WRITE,
    DONE
  } sc_state_t;

  // Ceiling log2; 0 for values of 1 or less
  function automatic int clogb2(input int value);
    int result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) result++;
    return result;
  endfunction

  // Width of an index register for 'value' entries, never narrower than one bit
  function automatic int addr_w(input int value);
    return (clogb2(value) < 1) ? 1 : clogb2(value);
  endfunction

  // Maximal-length feedback taps, bit k-1 set for tap k (supported widths 2..16)
  function automatic logic [15:0] lfsr_taps(input int p);
    case (p)
      2:       return 16'h0003;
      3:       return 16'h0006;
      4:       return 16'h000C;
      5:       return 16'h0014;
      6:       return 16'h0030;
      7:       return 16'h0060;
      8:       return 16'h00B8;
      9:       return 16'h0110;
      10:      return 16'h0240;
      11:      return 16'h0500;
      12:      return 16'h0829;
      13:      return 16'h100D;
      14:      return 16'h2015;
      15:      return 16'h6000;
      16:      return 16'hD008;
      default: return 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/sc_lfsr.sv
// rtl/sc_lfsr.sv - maximal-length Fibonacci LFSR with seed load, used as a stochastic number source
module sc_lfsr
  import sc_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] SEED  = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  output logic [WIDTH-1:0] q
);

  localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));

  logic feedback;

  assign feedback = ^(q & TAPS);

  // Shift toward the MSB feeding tap parity into bit 0; load parks the register on its seed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= SEED;
    end else if (load) begin
      q <= SEED;
    end else begin
      q <= {q[WIDTH-2:0], feedback};
    end
  end

endmodule

// File: rtl/sc_matmul_engine.sv
// rtl/sc_matmul_engine.sv - stochastic-computing matrix multiply engine; SC_MATMUL_INPUT_REUSE_EN keeps the input row across weight rows
module sc_matmul_engine
  import sc_pkg::*;
#(
  parameter int                          BATCH_SIZE        = 4,
  parameter int                          INPUT_FEATURES    = 4,
  parameter int                          OUTPUT_FEATURES   = 4,
  parameter int                          BINARY_PRECISION  = 8,
  parameter int                          STOCHASTIC_CYCLES = 1,
  parameter logic [BINARY_PRECISION-1:0] SEED_IN           = 8'h5A,
  parameter logic [BINARY_PRECISION-1:0] SEED_W            = 8'hC3
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         start,
  output logic                                         busy,
  output logic                                         done,
  output logic                                         in_req,
  output logic [addr_w(BATCH_SIZE)-1:0]                in_addr,
  input  logic                                         in_valid,
  input  logic [BINARY_PRECISION*INPUT_FEATURES-1:0]   in_data,
  output logic                                         w_req,
  output logic [addr_w(OUTPUT_FEATURES)-1:0]           w_addr,
  input  logic                                         w_valid,
  input  logic [BINARY_PRECISION*INPUT_FEATURES-1:0]   w_data,
  output logic                                         out_wr_en,
  output logic [addr_w(BATCH_SIZE*OUTPUT_FEATURES)-1:0] out_addr,
  output logic [BINARY_PRECISION-1:0]                  out_data,
  input  logic                                         out_ready
);

  localparam int M      = BATCH_SIZE;
  localparam int N      = INPUT_FEATURES;
  localparam int O      = OUTPUT_FEATURES;
  localparam int P      = BINARY_PRECISION;
  localparam int MW     = addr_w(M);
  localparam int OW     = addr_w(O);
  localparam int AW     = addr_w(M * O);
  localparam int SW     = addr_w(N);
  localparam int SHIFT  = clogb2(STOCHASTIC_CYCLES);
  // COMPUTE lasts 2^CW cycles, so the ones count needs one extra bit
  localparam int CW     = P + SHIFT;
  localparam int ONES_W = CW + 1;

  localparam logic [CW-1:0]     CYC_LAST = '1;
  localparam logic [SW-1:0]     SEL_LAST = SW'(N - 1);
  localparam logic [MW-1:0]     M_LAST   = MW'(M - 1);
  localparam logic [OW-1:0]     O_LAST   = OW'(O - 1);
  localparam logic [ONES_W-1:0] OUT_MAX  = ONES_W'((1 << P) - 1);

  sc_state_t         state;
  logic [MW-1:0]     m;
  logic [OW-1:0]     o;
  logic [CW-1:0]     cyc;
  logic [SW-1:0]     sel;
  logic [ONES_W-1:0] ones;
  logic [P*N-1:0]    in_row;
  logic [P*N-1:0]    w_row;
  logic [P-1:0]      lfsr_in;
  logic [P-1:0]      lfsr_w;
  logic              lfsr_load;
  logic [N-1:0]      in_bits;
  logic [N-1:0]      w_bits;
  logic [N-1:0]      prod_bits;
  logic              prod_bit;
  logic [ONES_W-1:0] ones_next;
  logic [ONES_W-1:0] scaled;
  logic [P-1:0]      result;
  logic [AW-1:0]     addr_calc;

  // Both sources sit on their seeds outside COMPUTE, so each result starts from the same sequence
  assign lfsr_load = (state != COMPUTE);

  sc_lfsr #(.WIDTH(P), .SEED(SEED_IN)) u_lfsr_in (
    .clk  (clk),
    .rst  (rst),
    .load (lfsr_load),
    .q    (lfsr_in)
  );

  sc_lfsr #(.WIDTH(P), .SEED(SEED_W)) u_lfsr_w (
    .clk  (clk),
    .rst  (rst),
    .load (lfsr_load),
    .q    (lfsr_w)
  );

  // Per-lane unipolar bitstreams: a lane emits 1 when the random sample falls below its value
  for (genvar n = 0; n < N; n++) begin : g_lane
    assign in_bits[n] = (lfsr_in < in_row[n*P +: P]);
    assign w_bits[n]  = (lfsr_w < w_row[n*P +: P]);
  end

  assign addr_calc = AW'(int'(m) * O + int'(o));

  // Multiply by AND, pick one lane per cycle, and scale the running count back to P bits
  always_comb begin
    prod_bits = in_bits & w_bits;
    prod_bit  = prod_bits[sel];
    ones_next = ones + ONES_W'(prod_bit);
    scaled    = ones_next >> SHIFT;
    result    = (scaled > OUT_MAX) ? '1 : scaled[P-1:0];
  end

  // Job sequencer: walks (m,o), drives fetch/write handshakes and accumulates the stochastic count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      m         <= '0;
      o         <= '0;
      cyc       <= '0;
      sel       <= '0;
      ones      <= '0;
      in_row    <= '0;
      w_row     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      in_req    <= 1'b0;
      in_addr   <= '0;
      w_req     <= 1'b0;
      w_addr    <= '0;
      out_wr_en <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy    <= 1'b1;
            in_req  <= 1'b1;
            in_addr <= m;
            state   <= LOAD_IN;
          end
        end
        LOAD_IN: begin
          if (in_valid) begin
            in_row <= in_data;
            in_req <= 1'b0;
            w_req  <= 1'b1;
            w_addr <= o;
            state  <= LOAD_W;
          end
        end
        LOAD_W: begin
          if (w_valid) begin
            w_row <= w_data;
            w_req <= 1'b0;
            cyc   <= '0;
            sel   <= '0;
            ones  <= '0;
            state <= COMPUTE;
          end
        end
        COMPUTE: begin
          ones <= ones_next;
          cyc  <= cyc + CW'(1);
          sel  <= (sel == SEL_LAST) ? '0 : sel + SW'(1);
          if (cyc == CYC_LAST) begin
            out_data  <= result;
            out_addr  <= addr_calc;
            out_wr_en <= 1'b1;
            state     <= WRITE;
          end
        end
        WRITE: begin
          if (out_ready) begin
            out_wr_en <= 1'b0;
            if (o != O_LAST) begin
              o <= o + OW'(1);
`ifdef SC_MATMUL_INPUT_REUSE_EN
              w_req  <= 1'b1;
              w_addr <= o + OW'(1);
              state  <= LOAD_W;
`else
              in_req  <= 1'b1;
              in_addr <= m;
              state   <= LOAD_IN;
`endif
            end else if (m != M_LAST) begin
              o       <= '0;
              m       <= m + MW'(1);
              in_req  <= 1'b1;
              in_addr <= m + MW'(1);
              state   <= LOAD_IN;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          m     <= '0;
          o     <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sc_matmul_engine.sv
// tb/tb_sc_matmul_engine.sv - randomized self-checking bench for sc_matmul_engine against an arithmetic reference model
`timescale 1ns/1ps
module tb_sc_matmul_engine;

  localparam int M = 4;
  localparam int N = 4;
  localparam int O = 4;
`ifdef SC_MATMUL_INPUT_REUSE_EN
  localparam int EXP_FETCH = M;
`else
  localparam int EXP_FETCH = M * O;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  logic        rst;
  logic        start, busy, done, in_req, in_valid, w_req, w_valid, out_wr_en, out_ready;
  logic [1:0]  in_addr, w_addr;
  logic [3:0]  out_addr;
  logic [7:0]  out_data;
  logic [31:0] in_data, w_data;

  logic        start2, busy2, done2, in_req2, in_valid2, w_req2, w_valid2, out_wr_en2, out_ready2;
  logic [0:0]  in_addr2, w_addr2, out_addr2;
  logic [7:0]  out_data2;
  logic [31:0] in_data2, w_data2;

  sc_matmul_engine #(
    .BATCH_SIZE(M), .INPUT_FEATURES(N), .OUTPUT_FEATURES(O),
    .BINARY_PRECISION(8), .STOCHASTIC_CYCLES(1), .SEED_IN(8'h5A), .SEED_W(8'hC3)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .in_req(in_req), .in_addr(in_addr), .in_valid(in_valid), .in_data(in_data),
    .w_req(w_req), .w_addr(w_addr), .w_valid(w_valid), .w_data(w_data),
    .out_wr_en(out_wr_en), .out_addr(out_addr), .out_data(out_data), .out_ready(out_ready)
  );

  sc_matmul_engine #(
    .BATCH_SIZE(1), .INPUT_FEATURES(N), .OUTPUT_FEATURES(1),
    .BINARY_PRECISION(8), .STOCHASTIC_CYCLES(4), .SEED_IN(8'h5A), .SEED_W(8'hC3)
  ) dut4 (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
    .in_req(in_req2), .in_addr(in_addr2), .in_valid(in_valid2), .in_data(in_data2),
    .w_req(w_req2), .w_addr(w_addr2), .w_valid(w_valid2), .w_data(w_data2),
    .out_wr_en(out_wr_en2), .out_addr(out_addr2), .out_data(out_data2), .out_ready(out_ready2)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference data and random-number sequences
  logic [7:0] xm [M][N];
  logic [7:0] wm [O][N];
  logic [7:0] seq_in [1024];
  logic [7:0] seq_w  [1024];

  // Primitive polynomial x^8+x^6+x^5+x^4+1 as a Fibonacci register growing toward the MSB
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  function automatic logic [31:0] pack_x(input int r);
    logic [31:0] v;
    for (int n = 0; n < N; n++) v[n*8 +: 8] = xm[r][n];
    return v;
  endfunction

  function automatic logic [31:0] pack_w(input int r);
    logic [31:0] v;
    for (int n = 0; n < N; n++) v[n*8 +: 8] = wm[r][n];
    return v;
  endfunction

  // Count coincident 1s of the two bitstreams over the window, lane chosen round-robin
  function automatic int model_out(input logic [31:0] xr, input logic [31:0] wr, input int t_len, input int shift);
    int cnt = 0;
    for (int t = 0; t < t_len; t++) begin
      int lane = t % N;
      if ((seq_in[t] < xr[lane*8 +: 8]) && (seq_w[t] < wr[lane*8 +: 8])) cnt++;
    end
    cnt = cnt >> shift;
    return (cnt > 255) ? 255 : cnt;
  endfunction

  task automatic fill(input int mode);
    for (int r = 0; r < M; r++)
      for (int n = 0; n < N; n++) begin
        xm[r][n] = (mode == 1) ? 8'd0 : (mode == 2) ? 8'd255 : 8'($urandom);
        wm[r][n] = (mode == 2) ? 8'd255 : 8'($urandom);
      end
  endtask

  // Input-row responder with random latency and spurious valids while not requested
  int in_fetches = 0;
  int in_gap = 0;
  initial begin
    in_valid = 1'b0;
    in_data  = '0;
    forever begin
      @(negedge clk);
      in_valid = 1'b0;
      if (in_req) begin
        if (in_gap == 0) begin
          in_valid = 1'b1;
          in_data  = pack_x(int'(in_addr));
          in_fetches++;
          in_gap = $urandom_range(0, 3);
        end else begin
          in_gap--;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        in_valid = 1'b1;
        in_data  = $urandom;
      end
    end
  end

  int w_gap = 0;
  initial begin
    w_valid = 1'b0;
    w_data  = '0;
    forever begin
      @(negedge clk);
      w_valid = 1'b0;
      if (w_req) begin
        if (w_gap == 0) begin
          w_valid = 1'b1;
          w_data  = pack_w(int'(w_addr));
          w_gap = $urandom_range(0, 3);
        end else begin
          w_gap--;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        w_valid = 1'b1;
        w_data  = $urandom;
      end
    end
  end

  // Output sink: random backpressure, optional long stall on the first write of a job
  int wa[$];
  int wd[$];
  int total_writes = 0;
  bit stall_first = 0;
  initial begin
    logic [3:0] hold_addr;
    logic [7:0] hold_data;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (out_wr_en && stall_first) begin
        stall_first = 0;
        out_ready   = 1'b0;
        hold_addr   = out_addr;
        hold_data   = out_data;
        repeat (10) begin
          @(negedge clk);
          check_eq("stall_wr_en", out_wr_en, 1);
          check_eq("stall_addr", out_addr, hold_addr);
          check_eq("stall_data", out_data, hold_data);
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      if (out_wr_en && out_ready) begin
        wa.push_back(int'(out_addr));
        wd.push_back(int'(out_data));
        total_writes++;
      end
    end
  end

  int done_cnt = 0;
  initial forever begin
    @(negedge clk);
    if (done) done_cnt++;
  end

  // Long-window engine: immediate responders, record handshake timing
  int  w2_accept = 0;
  int  wr2_rise = 0;
  int  wr2_data = 0;
  bit  wr2_seen = 0;
  initial begin
    in_valid2  = 1'b0;
    w_valid2   = 1'b0;
    in_data2   = {4{8'd128}};
    w_data2    = {4{8'd255}};
    out_ready2 = 1'b1;
    forever begin
      @(negedge clk);
      in_valid2 = in_req2;
      w_valid2  = w_req2;
      if (w_req2) w2_accept = cyc_cnt + 1;
      if (out_wr_en2 && !wr2_seen) begin
        wr2_seen = 1;
        wr2_rise = cyc_cnt;
        wr2_data = int'(out_data2);
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_job(input string tag, input bit do_stall, input bit sat_check);
    int f0;
    int d0;
    int budget;
    wa.delete();
    wd.delete();
    f0 = in_fetches;
    d0 = done_cnt;
    stall_first = do_stall;
    pulse_start();
    budget = 0;
    while (done_cnt == d0 && budget < 20000) begin
      @(negedge clk);
      budget++;
    end
    check_eq({tag, "_done_seen"}, done_cnt != d0, 1);
    repeat (3) @(negedge clk);
    check_eq({tag, "_done_pulses"}, done_cnt - d0, 1);
    check_eq({tag, "_busy_idle"}, busy, 0);
    check_eq({tag, "_writes"}, wa.size(), M * O);
    check_eq({tag, "_fetches"}, in_fetches - f0, EXP_FETCH);
    for (int i = 0; i < wa.size() && i < M * O; i++) begin
      check_eq({tag, "_addr"}, wa[i], i);
      check_eq({tag, "_data"}, wd[i], model_out(pack_x(i / O), pack_w(i % O), 256, 0));
      if (sat_check) check_eq({tag, "_ge252"}, wd[i] >= 252, 1);
    end
  endtask

  initial begin
    int budget;
    int d0;
    int w0;
    seq_in[0] = 8'h5A;
    seq_w[0]  = 8'hC3;
    for (int t = 1; t < 1024; t++) begin
      seq_in[t] = lfsr_step(seq_in[t-1]);
      seq_w[t]  = lfsr_step(seq_w[t-1]);
    end

    rst    = 1'b0;
    start  = 1'b0;
    start2 = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_in_req", in_req, 0);
    check_eq("rst_w_req", w_req, 0);
    check_eq("rst_wr_en", out_wr_en, 0);
    check_eq("rst_out_addr", out_addr, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_in_addr", in_addr, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    fill(1);
    run_job("zero", 0, 0);
    fill(2);
    run_job("full", 0, 1);
    fill(0);
    run_job("rand_a", 0, 0);
    fill(0);
    run_job("stall", 1, 0);

    // Abort during COMPUTE of (m=1,o=2)
    fill(0);
    wa.delete();
    wd.delete();
    d0 = done_cnt;
    pulse_start();
    budget = 0;
    while (!(wa.size() == 6 && busy && !in_req && !w_req && !out_wr_en) && budget < 5000) begin
      @(negedge clk);
      budget++;
    end
    check_eq("abort_reached", budget < 5000, 1);
    repeat (20) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_in_req", in_req, 0);
    check_eq("abort_w_req", w_req, 0);
    check_eq("abort_wr_en", out_wr_en, 0);
    check_eq("abort_out_addr", out_addr, 0);
    check_eq("abort_out_data", out_data, 0);
    @(negedge clk);
    rst = 1'b1;
    w0 = total_writes;
    repeat (600) @(negedge clk);
    check_eq("abort_no_writes", total_writes - w0, 0);
    check_eq("abort_no_done", done_cnt - d0, 0);
    run_job("rerun", 0, 0);

    // Four-window accumulation on the second engine
    wr2_seen = 0;
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    budget = 0;
    while (!done2 && budget < 3000) begin
      @(negedge clk);
      budget++;
    end
    check_eq("c4_done", done2, 1);
    check_eq("c4_len", wr2_rise - w2_accept, 1024);
    check_eq("c4_data", wr2_data, model_out({4{8'd128}}, {4{8'd255}}, 1024, 2));
    check_eq("c4_window", (wr2_data >= 120) && (wr2_data <= 136), 1);
    @(negedge clk);
    check_eq("c4_busy_idle", busy2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
